// File: rtl/sev_seg_pkg.sv
// Shared types and segment table for the seven-segment scan driver.
// Segment bit order is {g,f,e,d,c,b,a}; all values here are active-high.
package sev_seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h00;

    // 0-9 standard glyphs, 10-15 render A,b,C,d,E,F.
    localparam seg7_t HEX_SEG_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/sev_seg_decoder.sv
// Combinational hex digit to active-high segment decoder.
// Ports: value (4-bit digit), blank (force unlit), seg (segments {g..a}).
module sev_seg_decoder
    import sev_seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output seg7_t      seg
);

    assign seg = blank ? SEG_BLANK : HEX_SEG_TABLE[value];

endmodule

// File: rtl/sev_seg_scan_driver.sv
// Self-timed multiplexed N-digit seven-segment driver with per-frame snapshot.
// Ports: clk, rst (async high), en, blank_lz, digits_in, dp_in in;
//        an_out, seg_out, dp_out, digit_idx, frame_start out (registered).
module sev_seg_scan_driver
    import sev_seg_pkg::*;
#(
    parameter int  NUM_DIGITS     = 8,
    parameter int  TICK_DIV       = 100000,
    parameter bit  AN_ACTIVE_LOW  = 1'b1,
    parameter bit  SEG_ACTIVE_LOW = 1'b1,
    localparam int IDX_W          = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    blank_lz,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_start
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] LAST_P = PRESC_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]   LAST_I = IDX_W'(NUM_DIGITS - 1);

    // XOR masks that convert active-high values to pin polarity;
    // they also equal the "inactive/unlit" pin levels.
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam seg7_t                 SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    seg7_t                   seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fs_q, fs_d;

    logic                  tick;
    logic                  wrap;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [3:0]            cur_val;
    logic                  cur_blank;
    seg7_t                 cur_seg;

    // Counters and snapshot. snap_d already carries the freshly
    // sampled inputs on a wrap, so digit 0 of a new frame bypasses
    // the stale snapshot.
    always_comb begin
        tick    = en && (presc_q == LAST_P);
        wrap    = (idx_q == LAST_I);
        presc_d = presc_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        sdp_d   = sdp_q;
        if (tick) begin
            presc_d = '0;
            idx_d   = wrap ? '0 : idx_q + 1'b1;
            if (wrap) begin
                snap_d = digits_in;
                sdp_d  = dp_in;
            end
        end else if (en) begin
            presc_d = presc_q + 1'b1;
        end
    end

    // lz_mask[i]: digit i and every higher digit are zero.
    always_comb begin
        lz_mask = '0;
        lz_mask[NUM_DIGITS-1] = (snap_d[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lz_mask[i] = lz_mask[i+1] && (snap_d[4*i +: 4] == 4'h0);
        end
    end

    always_comb begin
        cur_val   = snap_d[4*idx_d +: 4];
        cur_blank = blank_lz && lz_mask[idx_d] && (idx_d != '0);
    end

    sev_seg_decoder u_dec (
        .value (cur_val),
        .blank (cur_blank),
        .seg   (cur_seg)
    );

    // Pins change only on a tick (or go dark when disabled).
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        fs_d  = 1'b0;
        if (!en) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
        end else if (tick) begin
            an_d  = (ONE_HOT0 << idx_d) ^ AN_OFF;
            seg_d = cur_seg ^ SEG_OFF;
            dp_d  = sdp_d[idx_d] ^ DP_OFF;
            fs_d  = wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= LAST_I;
            snap_q  <= '0;
            sdp_q   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            sdp_q   <= sdp_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fs_q    <= fs_d;
        end
    end

    assign an_out      = an_q;
    assign seg_out     = seg_q;
    assign dp_out      = dp_q;
    assign digit_idx   = idx_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Directed scoreboard bench for sev_seg_scan_driver (8 digits, 4 clk/slot).
// Ports: none; drives the DUT and reports one summary line.
module tb_sev_seg_scan_driver;

    localparam int N  = 8;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        blank_lz;
    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic [7:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [2:0]  digit_idx;
    logic        frame_start;

    always #5 clk = ~clk;

    sev_seg_scan_driver #(
        .NUM_DIGITS     (N),
        .TICK_DIV       (TD),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .blank_lz    (blank_lz),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .an_out      (an_out),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] idx;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   fs_seen = 0;

    int          m_presc;
    int          m_idx;
    logic [31:0] m_snap;
    logic [7:0]  m_sdp;
    exp_t        m_out;

    function automatic logic [6:0] hexseg(input int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
           12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] seg_pin(input int v);
        return ~hexseg(v);
    endfunction

    function automatic logic [7:0] an_pin(input int k);
        logic [7:0] one = 8'h01;
        return ~(one << k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_idx   = N - 1;
        m_snap  = '0;
        m_sdp   = '0;
        m_out   = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, idx: 3'd7, fs: 1'b0};
    endtask

    // Predicts the pins after the coming edge from the inputs now applied.
    task automatic model_step();
        logic [3:0] d;
        logic       blank;
        m_out.fs = 1'b0;
        if (!en) begin
            m_out.an  = 8'hFF;
            m_out.seg = 7'h7F;
            m_out.dp  = 1'b1;
        end else if (m_presc == TD - 1) begin
            m_presc = 0;
            if (m_idx == N - 1) begin
                m_idx    = 0;
                m_snap   = digits_in;
                m_sdp    = dp_in;
                m_out.fs = 1'b1;
            end else begin
                m_idx++;
            end
            d     = m_snap[4*m_idx +: 4];
            blank = blank_lz && (m_idx != 0) && ((m_snap >> (4 * m_idx)) == 32'h0);
            m_out.an  = an_pin(m_idx);
            m_out.seg = blank ? 7'h7F : seg_pin(int'(d));
            m_out.dp  = ~m_sdp[m_idx];
        end else begin
            m_presc++;
        end
        m_out.idx = 3'(m_idx);
        sb_q.push_back(m_out);
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("an", an_out, e.an);
        chk("seg", seg_out, e.seg);
        chk("dp", dp_out, e.dp);
        chk("idx", digit_idx, e.idx);
        chk("fs", frame_start, e.fs);
        if (frame_start === 1'b1) fs_seen++;
    endtask

    // Advance to the next tick that lands on digit t.
    task automatic goto_idx(input int t);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(m_idx == t && m_presc == 0) && n < 64);
    endtask

    task automatic apply_reset(input int hold);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_an", an_out, 8'hFF);
        chk("rst_seg", seg_out, 7'h7F);
        chk("rst_dp", dp_out, 1'b1);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_idx", digit_idx, 3'd7);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("rst_hold_an", an_out, 8'hFF);
            chk("rst_hold_seg", seg_out, 7'h7F);
        end
        rst = 1'b0;
    endtask

    initial begin
        int fs0;
        int n;
        rst       = 1'b0;
        en        = 1'b1;
        blank_lz  = 1'b0;
        digits_in = 32'h1234_5678;
        dp_in     = 8'h00;
        #2;
        apply_reset(3);

        // First tick: snapshot + digit 0.
        repeat (3) cycle();
        chk("pre_tick_an", an_out, 8'hFF);
        cycle();
        chk("t1_idx", digit_idx, 3'd0);
        chk("t1_an", an_out, 8'hFE);
        chk("t1_seg", seg_out, 7'h00);
        chk("t1_fs", frame_start, 1'b1);

        // Scan order and frame rate.
        for (int k = 1; k < N; k++) begin
            repeat (TD) cycle();
            chk("scan_an", an_out, an_pin(k));
        end
        repeat (TD) cycle();
        chk("wrap_an", an_out, 8'hFE);
        chk("wrap_fs", frame_start, 1'b1);
        fs0 = fs_seen;
        repeat (64) cycle();
        chk("frame_rate", fs_seen - fs0, 2);

        // Snapshot isolation.
        goto_idx(3);
        digits_in = 32'h9999_9999;
        for (int k = 4; k < N; k++) begin
            goto_idx(k);
            chk("snap_old", seg_out, seg_pin(8 - k));
        end
        for (int k = 0; k < N; k++) begin
            goto_idx(k);
            chk("snap_new", seg_out, seg_pin(9));
        end

        // Leading-zero blanking.
        digits_in = 32'h0000_0042;
        blank_lz  = 1'b1;
        goto_idx(0);
        chk("lz_d0", seg_out, seg_pin(2));
        goto_idx(1);
        chk("lz_d1", seg_out, seg_pin(4));
        for (int k = 2; k < N; k++) begin
            goto_idx(k);
            chk("lz_blank", seg_out, 7'h7F);
            chk("lz_blank_an", an_out, an_pin(k));
        end
        digits_in = 32'h0;
        goto_idx(0);
        chk("lz_zero_d0", seg_out, seg_pin(0));
        goto_idx(1);
        chk("lz_zero_d1", seg_out, 7'h7F);
        goto_idx(7);
        chk("lz_zero_d7", seg_out, 7'h7F);
        blank_lz = 1'b0;
        for (int k = 0; k < N; k++) begin
            goto_idx(k);
            chk("nolz_zero", seg_out, seg_pin(0));
        end

        // Hex glyphs and decimal point.
        digits_in = 32'hFEDC_BA98;
        dp_in     = 8'h04;
        goto_idx(0);
        chk("hex_d0", seg_out, seg_pin(8));
        chk("hex_d0_dp", dp_out, 1'b1);
        goto_idx(2);
        chk("hex_d2", seg_out, seg_pin(10));
        chk("hex_d2_dp", dp_out, 1'b0);
        goto_idx(7);
        chk("hex_d7", seg_out, seg_pin(15));
        chk("hex_d7_dp", dp_out, 1'b1);

        // Enable gating.
        goto_idx(5);
        en = 1'b0;
        cycle();
        chk("dis_an", an_out, 8'hFF);
        chk("dis_idx", digit_idx, 3'd5);
        repeat (6) cycle();
        chk("dis_hold_idx", digit_idx, 3'd5);
        en = 1'b1;
        n = 0;
        while (digit_idx === 3'd5 && n < 16) begin
            cycle();
            n++;
        end
        chk("resume_bound", n < 16, 1'b1);
        chk("resume_idx", digit_idx, 3'd6);
        chk("resume_an", an_out, an_pin(6));

        // Reset mid-frame, then power-up behaviour again.
        goto_idx(2);
        apply_reset(2);
        repeat (TD) cycle();
        chk("rerst_idx", digit_idx, 3'd0);
        chk("rerst_an", an_out, 8'hFE);
        chk("rerst_seg", seg_out, seg_pin(8));
        chk("rerst_fs", frame_start, 1'b1);
        goto_idx(7);
        chk("rerst_d7", seg_out, seg_pin(15));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
